// File: rtl/prefix_add_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
// Maps each prefix level onto the pipeline stage that evaluates it.
package prefix_add_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_WIDTH = 16;
    localparam int LEVELS    = clog2(DEF_WIDTH);

    // Even split of levels over stages; the trailing stages absorb the remainder.
    function automatic int stage_nlev(input int s, input int levels, input int lat);
        int base;
        int extra;
        base  = levels / lat;
        extra = levels % lat;
        return base + ((s >= lat - extra) ? 1 : 0);
    endfunction

    function automatic int stage_first(input int s, input int levels, input int lat);
        int f;
        f = 0;
        for (int t = 0; t < s; t++) f += stage_nlev(t, levels, lat);
        return f;
    endfunction

    function automatic int level_stage(input int k, input int levels, input int lat);
        int st;
        int f;
        st = 0;
        for (int s = 0; s < lat; s++) begin
            f = stage_first(s, levels, lat);
            if (k >= f && k < f + stage_nlev(s, levels, lat)) st = s;
        end
        return st;
    endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone black cell: merges a higher (g,p) group with the adjacent lower group.
module prefix_gp_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);
    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;
endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
// Optional signed-overflow saturation is built when PREFIX_ADD_SAT_EN is defined.
module prefix_adder_pipe
    import prefix_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
`ifdef PREFIX_ADD_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int LV = clog2(WIDTH);

    // Handshake: a beat moves on a side when valid && ready at the rising edge;
    // a stage loads when it is empty or its successor loads, so in_ready has no bubbles.

    logic [WIDTH-1:0] b_eff, init_g, init_p;
    logic             c0;

    assign b_eff = in_sub ? ~in_b : in_b;
    assign c0    = in_sub | in_cin;
    assign init_p = in_a ^ b_eff;

    // Carry-in is folded into bit 0 so log2(WIDTH) levels reach every carry.
    always_comb begin
        init_g    = in_a & b_eff;
        init_g[0] = init_g[0] | (init_p[0] & c0);
    end

    logic [WIDTH-1:0] si_g [LAT];
    logic [WIDTH-1:0] si_p [LAT];
    logic [WIDTH-1:0] so_g [LAT];
    logic [WIDTH-1:0] so_p [LAT];
    logic [WIDTH-1:0] li_g [LV];
    logic [WIDTH-1:0] li_p [LV];
    logic [WIDTH-1:0] lo_g [LV];
    logic [WIDTH-1:0] lo_p [LV];

    gp_t  [WIDTH-1:0] gp_q [LAT];
    logic [WIDTH-1:0] p0_q [LAT];
    logic [WIDTH-1:0] np0  [LAT];
    logic [LAT-1:0]   v_q, ld, nv, c0_q, nc0;
`ifdef PREFIX_ADD_SAT_EN
    logic [LAT-1:0]   sat_q, amsb_q, nsat, namsb;
`endif

    for (genvar k = 0; k < LV; k++) begin : g_lvl
        localparam int ST = level_stage(k, LV, LAT);
        localparam int D  = 1 << k;
        logic [WIDTH-1:0] og, op;

        if (k == stage_first(ST, LV, LAT)) begin : g_src_stage
            assign li_g[k] = si_g[ST];
            assign li_p[k] = si_p[ST];
        end else begin : g_src_level
            assign li_g[k] = lo_g[k-1];
            assign li_p[k] = lo_p[k-1];
        end

        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            if (j >= D) begin : g_cell
                prefix_gp_cell u_cell (
                    .g_hi  (li_g[k][j]),
                    .p_hi  (li_p[k][j]),
                    .g_lo  (li_g[k][j-D]),
                    .p_lo  (li_p[k][j-D]),
                    .g_out (og[j]),
                    .p_out (op[j])
                );
            end else begin : g_pass
                assign og[j] = li_g[k][j];
                assign op[j] = li_p[k][j];
            end
        end

        assign lo_g[k] = og;
        assign lo_p[k] = op;
    end

    for (genvar s = 0; s < LAT; s++) begin : g_stg
        localparam int NL = stage_nlev(s, LV, LAT);
        localparam int F  = stage_first(s, LV, LAT);

        if (s == 0) begin : g_first
            assign si_g[0] = init_g;
            assign si_p[0] = init_p;
            assign nv[0]   = in_valid;
            assign np0[0]  = init_p;
            assign nc0[0]  = c0;
`ifdef PREFIX_ADD_SAT_EN
            assign nsat[0]  = in_sat;
            assign namsb[0] = in_a[WIDTH-1];
`endif
        end else begin : g_next
            logic [WIDTH-1:0] ug, up;
            always_comb begin
                for (int j = 0; j < WIDTH; j++) begin
                    ug[j] = gp_q[s-1][j].g;
                    up[j] = gp_q[s-1][j].p;
                end
            end
            assign si_g[s] = ug;
            assign si_p[s] = up;
            assign nv[s]   = v_q[s-1];
            assign np0[s]  = p0_q[s-1];
            assign nc0[s]  = c0_q[s-1];
`ifdef PREFIX_ADD_SAT_EN
            assign nsat[s]  = sat_q[s-1];
            assign namsb[s] = amsb_q[s-1];
`endif
        end

        if (NL == 0) begin : g_nolev
            assign so_g[s] = si_g[s];
            assign so_p[s] = si_p[s];
        end else begin : g_lev
            assign so_g[s] = lo_g[F+NL-1];
            assign so_p[s] = lo_p[F+NL-1];
        end

        if (s == LAT - 1) begin : g_ld_out
            assign ld[s] = !v_q[s] | out_ready;
        end else begin : g_ld_mid
            assign ld[s] = !v_q[s] | ld[s+1];
        end
    end

    // Payload only moves with a valid beat, so idle stages keep their last contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            c0_q <= '0;
`ifdef PREFIX_ADD_SAT_EN
            sat_q  <= '0;
            amsb_q <= '0;
`endif
            for (int s = 0; s < LAT; s++) begin
                gp_q[s] <= '0;
                p0_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < LAT; s++) begin
                if (ld[s]) begin
                    v_q[s] <= nv[s];
                    if (nv[s]) begin
                        p0_q[s] <= np0[s];
                        c0_q[s] <= nc0[s];
`ifdef PREFIX_ADD_SAT_EN
                        sat_q[s]  <= nsat[s];
                        amsb_q[s] <= namsb[s];
`endif
                        for (int j = 0; j < WIDTH; j++) begin
                            gp_q[s][j] <= '{g: so_g[s][j], p: so_p[s][j]};
                        end
                    end
                end
            end
        end
    end

    logic [WIDTH:0]   cv;
    logic [WIDTH-1:0] sum_w;

    always_comb begin
        cv[0] = c0_q[LAT-1];
        for (int i = 0; i < WIDTH; i++) cv[i+1] = gp_q[LAT-1][i].g;
    end

    assign sum_w     = p0_q[LAT-1] ^ cv[WIDTH-1:0];
    assign out_cout  = cv[WIDTH];
    assign out_ovf   = cv[WIDTH] ^ cv[WIDTH-1];
    assign out_valid = v_q[LAT-1];
    assign in_ready  = ld[0];

`ifdef PREFIX_ADD_SAT_EN
    // On overflow both operands share A's sign, so A's sign picks the clamp direction.
    assign out_sum = (sat_q[LAT-1] && out_ovf)
                   ? (amsb_q[LAT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                   : sum_w;
`else
    assign out_sum = sum_w;
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe: directed corner cases, backpressure,
// mid-stream reset and randomized valid/ready traffic against an arithmetic model.
module tb_prefix_adder_pipe;
    localparam int WIDTH = 16;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             in_sub = 1'b0;
`ifdef PREFIX_ADD_SAT_EN
    logic             in_sat = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    always #5 clk = ~clk;

    prefix_adder_pipe #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
`ifdef PREFIX_ADD_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_out    = 0;
    logic pending = 1'b0;
    logic [WIDTH+1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer add in WIDTH+1 bits; signed overflow from operand/result signs.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub, input logic sat);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] sum;
        logic             ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub | cin)};
        sum  = full[WIDTH-1:0];
        ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        if (sat && ovf) sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return {ovf, full[WIDTH], sum};
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    function automatic logic cur_sat();
`ifdef PREFIX_ADD_SAT_EN
        return in_sat;
`else
        return 1'b0;
`endif
    endfunction

    // One clock of traffic: drive at negedge, then record both handshakes before the posedge.
    task automatic cycle(input logic want_valid, input logic ordy);
        @(negedge clk);
        if (!pending) begin
            if (want_valid) begin
                in_a   = rand_word();
                in_b   = rand_word();
                in_cin = 1'($urandom_range(0, 1));
                in_sub = 1'($urandom_range(0, 1));
`ifdef PREFIX_ADD_SAT_EN
                in_sat = 1'($urandom_range(0, 1));
`endif
                in_valid = 1'b1;
                pending  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check_eq("spurious_out", 1'b1, 1'b0);
            else check_eq("result", {out_ovf, out_cout, out_sum}, exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_cin, in_sub, cur_sat()));
            n_acc++;
            pending = 1'b0;
        end
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, input logic sat,
                            input logic [WIDTH+1:0] exp);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
`ifdef PREFIX_ADD_SAT_EN
        in_sat = sat;
`else
        if (sat) $display("note: %s saturation request ignored in this build", tag);
`endif
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq(tag, {out_ovf, out_cout, out_sum}, exp);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc0, out0;
        logic [WIDTH-1:0] held;

        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_outputs", {out_ovf, out_cout, out_sum}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check_eq("rst_in_ready", in_ready, 1'b1);

        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        directed("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        directed("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, {1'b0, 1'b0, 16'hFFFE});
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, {1'b1, 1'b1, 16'h7FFF});
        directed("sub_ign_cin", 16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
`ifdef PREFIX_ADD_SAT_EN
        directed("sat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 16'h7FFF});
        directed("sat_neg", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 16'h8000});
`endif

        // Backpressure: four beats offered against a stalled output.
        acc0 = n_acc;
        out0 = n_out;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            cycle((n_acc - acc0) < 4, 1'b0);
            if (i == 2) held = out_sum;
        end
        check_eq("bp_accepted", n_acc - acc0, LAT);
        check_eq("bp_in_ready", in_ready, 1'b0);
        check_eq("bp_stable", out_sum, held);
        cycle((n_acc - acc0) < 4, 1'b1);
        check_eq("bp_release_ready", in_ready, 1'b1);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || (n_acc - acc0) < 4); i++)
            cycle((n_acc - acc0) < 4, 1'b1);
        check_eq("bp_all_out", n_out - out0, 4);
        check_eq("bp_drained", exp_q.size(), 0);

        // Reset with two beats in flight.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_valid", out_valid, 1'b0);
        check_eq("midrst_outputs", {out_ovf, out_cout, out_sum}, '0);
        exp_q.delete();
        pending  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check_eq("midrst_in_ready", in_ready, 1'b1);
        out0 = n_out;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        check_eq("midrst_no_stale", n_out - out0, 0);

        // Randomized traffic with random valid and ready.
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || pending); i++) cycle(1'b0, 1'b1);
        check_eq("final_drained", exp_q.size(), 0);
        check_eq("final_count", n_out > 1000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
